// File: rtl/nn_accel_ctrl_if.sv
// Register-port bus between the RISC-V core (master) and nn_accel_ctrl (slave).
interface nn_accel_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              cfg_write_valid;
   logic              cfg_write_ready;
   logic [ADDR_W-1:0] cfg_write_address;
   logic [DATA_W-1:0] cfg_write_data;
   logic              cfg_read_valid;
   logic              cfg_read_ready;
   logic [ADDR_W-1:0] cfg_read_address;
   logic [DATA_W-1:0] cfg_read_data;
   logic              cfg_read_data_valid;

   modport master (
      output cfg_write_valid, cfg_write_address, cfg_write_data,
      output cfg_read_valid, cfg_read_address,
      input  cfg_write_ready, cfg_read_ready, cfg_read_data, cfg_read_data_valid
   );

   modport slave (
      input  cfg_write_valid, cfg_write_address, cfg_write_data,
      input  cfg_read_valid, cfg_read_address,
      output cfg_write_ready, cfg_read_ready, cfg_read_data, cfg_read_data_valid
   );
endinterface

// File: rtl/nn_accel_ctrl.sv
// Controller for the 4x4 matrix-vector MAC datapath: register file, row/column
// sequencer streaming operand pairs to a shared MAC, result capture with
// optional ReLU, sticky status and level interrupt.
module nn_accel_ctrl #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   nn_accel_ctrl_if.slave    cfg,
   output logic              mac_valid,
   input  logic              mac_ready,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic              mac_clear,
   output logic              mac_last,
   input  logic [DATA_W-1:0] mac_result,
   input  logic              mac_result_valid,
   output logic              busy,
   output logic              done_irq
);

   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(8'h20);
   localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(8'h60);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // True when a word-aligned address falls inside a block of 'words' registers.
   function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input int words);
      return (a[1:0] == 2'b00) && (int'(a) >= int'(base)) &&
             (int'(a) < int'(base) + 4 * words);
   endfunction

   // Word index of an address within a register block.
   function automatic logic [3:0] addr_idx(input logic [ADDR_W-1:0] a,
                                           input logic [ADDR_W-1:0] base);
      return 4'((a - base) >> 2);
   endfunction

   state_e             state_q, state_d;
   logic [1:0]         row_q, row_d;
   logic [1:0]         col_q, col_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   logic [DATA_W-1:0]  in_q  [4];
   logic [DATA_W-1:0]  w_q   [16];
   logic [DATA_W-1:0]  out_q [4];
   logic               irq_en_q, relu_en_q;
   logic               done_q, tmo_err_q, bwe_q;
   logic               rdy_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic               rd_valid_q;

   logic               wr_fire_s, rd_fire_s;
   logic               wr_ctrl_s, wr_stat_s, wr_in_s, wr_w_s;
   logic [1:0]         wr_in_idx_s;
   logic [3:0]         wr_w_idx_s;
   logic               busy_s, start_req_s, start_s, bwe_set_s;
   logic               store_s, tmo_evt_s, done_evt_s;
   logic [DATA_W-1:0]  rd_mux_s;
   logic [DATA_W-1:0]  wd_s;

   assign wd_s = cfg.cfg_write_data;

   // Decode register writes and classify them against the sequencer state.
   always_comb begin
      busy_s      = (state_q != S_IDLE);
      wr_fire_s   = cfg.cfg_write_valid & rdy_q;
      rd_fire_s   = cfg.cfg_read_valid & rdy_q;
      wr_ctrl_s   = wr_fire_s && (cfg.cfg_write_address == A_CTRL);
      wr_stat_s   = wr_fire_s && (cfg.cfg_write_address == A_STAT);
      wr_in_s     = wr_fire_s && addr_hit(cfg.cfg_write_address, A_IN, 4);
      wr_w_s      = wr_fire_s && addr_hit(cfg.cfg_write_address, A_W, 16);
      wr_in_idx_s = 2'(addr_idx(cfg.cfg_write_address, A_IN));
      wr_w_idx_s  = addr_idx(cfg.cfg_write_address, A_W);
      start_req_s = wr_ctrl_s & wd_s[0];
      start_s     = start_req_s & ~busy_s;
      bwe_set_s   = busy_s & (start_req_s | wr_in_s | wr_w_s);
   end

   // Sequencer state, row/column pointers and result timeout counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         row_q   <= 2'd0;
         col_q   <= 2'd0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic: issue four terms per row, wait for the row result, advance.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      tmo_d      = tmo_q;
      store_s    = 1'b0;
      tmo_evt_s  = 1'b0;
      done_evt_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_ISSUE;
               row_d   = 2'd0;
               col_d   = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (mac_ready) begin
               if (col_q == 2'd3) begin
                  col_d   = 2'd0;
                  tmo_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still counts.
            if (mac_result_valid) begin
               store_s = 1'b1;
               state_d = S_NEXT;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               tmo_evt_s = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_NEXT: begin
            if (row_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q + 2'd1;
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            done_evt_s = 1'b1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // MAC operand stream driven from the current row/column pointers.
   always_comb begin
      mac_valid = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      mac_clear = 1'b0;
      mac_last  = 1'b0;
      if (state_q == S_ISSUE) begin
         mac_valid = 1'b1;
         mac_a     = w_q[{row_q, col_q}];
         mac_b     = in_q[col_q];
         mac_clear = (col_q == 2'd0);
         mac_last  = (col_q == 2'd3);
      end else begin
         mac_valid = 1'b0;
      end
   end

   // Operand storage (locked while running) and captured row results.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            in_q[k]  <= '0;
            out_q[k] <= '0;
         end
         for (int k = 0; k < 16; k++) begin
            w_q[k] <= '0;
         end
      end else begin
         if (wr_in_s && !busy_s) begin
            in_q[wr_in_idx_s] <= wd_s;
         end
         if (wr_w_s && !busy_s) begin
            w_q[wr_w_idx_s] <= wd_s;
         end
         if (store_s) begin
            out_q[row_q] <= (relu_en_q && mac_result[DATA_W-1]) ? '0 : mac_result;
         end
      end
   end

   // Control bits and sticky status; an event setting a bit beats a same-cycle clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q  <= 1'b0;
         relu_en_q <= 1'b0;
         done_q    <= 1'b0;
         tmo_err_q <= 1'b0;
         bwe_q     <= 1'b0;
      end else begin
         if (wr_ctrl_s) begin
            irq_en_q  <= wd_s[1];
            relu_en_q <= wd_s[2];
         end
         done_q    <= done_evt_s | (done_q    & ~(wr_stat_s & wd_s[1]));
         tmo_err_q <= tmo_evt_s  | (tmo_err_q & ~(wr_stat_s & wd_s[2]));
         bwe_q     <= bwe_set_s  | (bwe_q     & ~(wr_stat_s & wd_s[3]));
      end
   end

   // Read-side address decode; unmapped or misaligned addresses return zero.
   always_comb begin
      rd_mux_s = '0;
      if (cfg.cfg_read_address == A_CTRL) begin
         rd_mux_s = DATA_W'({relu_en_q, irq_en_q, 1'b0});
      end else if (cfg.cfg_read_address == A_STAT) begin
         rd_mux_s = DATA_W'({bwe_q, tmo_err_q, done_q, busy_s});
      end else if (addr_hit(cfg.cfg_read_address, A_IN, 4)) begin
         rd_mux_s = in_q[2'(addr_idx(cfg.cfg_read_address, A_IN))];
      end else if (addr_hit(cfg.cfg_read_address, A_W, 16)) begin
         rd_mux_s = w_q[addr_idx(cfg.cfg_read_address, A_W)];
      end else if (addr_hit(cfg.cfg_read_address, A_OUT, 4)) begin
         rd_mux_s = out_q[2'(addr_idx(cfg.cfg_read_address, A_OUT))];
      end else begin
         rd_mux_s = '0;
      end
   end

   // Registered read response and always-ready handshake after reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rdy_q      <= 1'b1;
         rd_valid_q <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_q <= rd_mux_s;
         end
      end
   end

   assign cfg.cfg_write_ready     = rdy_q;
   assign cfg.cfg_read_ready      = rdy_q;
   assign cfg.cfg_read_data       = rd_data_q;
   assign cfg.cfg_read_data_valid = rd_valid_q;
   assign busy                    = busy_s;
   assign done_irq                = done_q & irq_en_q;

endmodule

// File: tb/tb_nn_accel_ctrl.sv
// Self-checking bench for nn_accel_ctrl: directed scenarios plus randomized
// runs against a behavioural matrix-vector model and a simple MAC responder.
module tb_nn_accel_ctrl;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 255;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   nn_accel_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cfg ();

   logic              mac_valid;
   logic              mac_ready = 1'b0;
   logic [DATA_W-1:0] mac_a, mac_b;
   logic              mac_clear, mac_last;
   logic [DATA_W-1:0] mac_result = '0;
   logic              mac_result_valid = 1'b0;
   logic              busy, done_irq;

   nn_accel_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .cfg              (cfg),
      .mac_valid        (mac_valid),
      .mac_ready        (mac_ready),
      .mac_a            (mac_a),
      .mac_b            (mac_b),
      .mac_clear        (mac_clear),
      .mac_last         (mac_last),
      .mac_result       (mac_result),
      .mac_result_valid (mac_result_valid),
      .busy             (busy),
      .done_irq         (done_irq)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] a; logic [31:0] b; bit clr; bit lst; } beat_t;
   logic signed [31:0] m_in [4];
   logic signed [31:0] m_w  [4][4];
   logic signed [31:0] m_out[4];
   logic signed [31:0] m_pend[4];
   bit m_irq, m_relu, m_done, m_tmo, m_berr, m_busy;
   beat_t       exp_beats[$];
   logic [31:0] exp_rd[$];
   logic [7:0]  exp_rd_addr[$];

   // MAC responder controls
   int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random
   int mac_lat    = 2;
   bit res_en     = 1'b1;
   int res_cnt    = 0;
   int beats_acc  = 0;
   logic signed [31:0] acc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_in[i] = 0; m_out[i] = 0; m_pend[i] = 0;
         for (int j = 0; j < 4; j++) m_w[i][j] = 0;
      end
      {m_irq, m_relu, m_done, m_tmo, m_berr, m_busy} = 6'b0;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      if (a[1:0] != 2'b00) return 32'd0;
      if (a == 8'h00) return {29'd0, m_relu, m_irq, 1'b0};
      if (a == 8'h04) return {28'd0, m_berr, m_tmo, m_done, m_busy};
      if (a >= 8'h10 && a < 8'h20) return m_in[(a - 8'h10) / 4];
      if (a >= 8'h20 && a < 8'h60) return m_w[((a - 8'h20) / 4) / 4][((a - 8'h20) / 4) % 4];
      if (a >= 8'h60 && a < 8'h70) return m_out[(a - 8'h60) / 4];
      return 32'd0;
   endfunction

   function automatic void start_run();
      logic signed [31:0] s;
      m_busy    = 1'b1;
      beats_acc = 0;
      for (int i = 0; i < 4; i++) begin
         s = 0;
         for (int j = 0; j < 4; j++) begin
            s = s + m_w[i][j] * m_in[j];
            exp_beats.push_back('{a: m_w[i][j], b: m_in[j], clr: (j == 0), lst: (j == 3)});
         end
         m_pend[i] = (m_relu && s < 0) ? 32'sd0 : s;
      end
   endfunction

   // ---------------- bus tasks ----------------
   task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
      if (a == 8'h00) begin
         m_irq  = d[1];
         m_relu = d[2];
         if (d[0]) begin
            if (m_busy) m_berr = 1'b1;
            else start_run();
         end
      end else if (a == 8'h04) begin
         if (d[1]) m_done = 1'b0;
         if (d[2]) m_tmo  = 1'b0;
         if (d[3]) m_berr = 1'b0;
      end else if (a[1:0] == 2'b00 && a >= 8'h10 && a < 8'h60) begin
         if (m_busy) m_berr = 1'b1;
         else if (a < 8'h20) m_in[(a - 8'h10) / 4] = d;
         else m_w[((a - 8'h20) / 4) / 4][((a - 8'h20) / 4) % 4] = d;
      end
      cfg.cfg_write_valid   = 1'b1;
      cfg.cfg_write_address = a;
      cfg.cfg_write_data    = d;
      @(negedge clock);
      cfg.cfg_write_valid   = 1'b0;
   endtask

   task automatic cfg_rd(input logic [7:0] a);
      exp_rd.push_back(model_read(a));
      exp_rd_addr.push_back(a);
      cfg.cfg_read_valid   = 1'b1;
      cfg.cfg_read_address = a;
      @(negedge clock);
      cfg.cfg_read_valid   = 1'b0;
   endtask

   task automatic load(input logic signed [31:0] in0, in1, in2, in3, input bit identity);
      logic signed [31:0] v[4];
      v[0] = in0; v[1] = in1; v[2] = in2; v[3] = in3;
      for (int j = 0; j < 4; j++) cfg_wr(8'(8'h10 + 4 * j), v[j]);
      for (int k = 0; k < 16; k++)
         cfg_wr(8'(8'h20 + 4 * k), identity ? ((k / 4 == k % 4) ? 32'd1 : 32'd0) : 32'd1);
   endtask

   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (busy === 1'b1 && n < max) begin
         n++;
         @(negedge clock);
      end
      if (n >= max) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
      end
   endtask

   task automatic finish_run(input bit ok);
      m_busy = 1'b0;
      if (ok) begin
         for (int i = 0; i < 4; i++) m_out[i] = m_pend[i];
         m_done = 1'b1;
         chk("beats_left", 32'(exp_beats.size()), 32'd0);
      end else begin
         m_tmo = 1'b1;
      end
      exp_beats.delete();
   endtask

   task automatic read_results();
      for (int i = 0; i < 4; i++) cfg_rd(8'(8'h60 + 4 * i));
      cfg_rd(8'h04);
      cfg_rd(8'h00);
   endtask

   // ---------------- MAC responder + per-cycle compare ----------------
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         mac_ready        = 1'b0;
         mac_result_valid = 1'b0;
         res_cnt          = 0;
         chk("reset_outputs", {27'd0, cfg.cfg_write_ready, cfg.cfg_read_ready, busy, mac_valid, done_irq}, 32'd0);
      end else begin
         mac_result_valid = 1'b0;
         if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) mac_result_valid = 1'b1;
         end
         case (ready_mode)
            0:       mac_ready = 1'b1;
            1:       mac_ready = ~mac_ready;
            default: mac_ready = 1'($urandom_range(0, 1));
         endcase
         if (mac_valid === 1'b1) begin
            if (exp_beats.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mac_beat: unexpected mac_valid, a=0x%08h expected no beat", mac_a);
            end else begin
               chk("mac_a", mac_a, exp_beats[0].a);
               chk("mac_b", mac_b, exp_beats[0].b);
               chk("mac_clear_last", {30'd0, mac_clear, mac_last},
                   {30'd0, exp_beats[0].clr, exp_beats[0].lst});
               if (mac_ready) begin
                  void'(exp_beats.pop_front());
                  beats_acc++;
                  acc = mac_clear ? $signed(mac_a) * $signed(mac_b)
                                  : acc + $signed(mac_a) * $signed(mac_b);
                  if (mac_last) begin
                     mac_result = acc;
                     if (res_en) res_cnt = mac_lat;
                  end
               end
            end
         end
         if (cfg.cfg_read_data_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_valid: unexpected read data 0x%08h, expected none", cfg.cfg_read_data);
            end else begin
               chk($sformatf("read_0x%02h", exp_rd_addr[0]), cfg.cfg_read_data, exp_rd[0]);
               void'(exp_rd.pop_front());
               void'(exp_rd_addr.pop_front());
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      cfg.cfg_write_valid   = 1'b0;
      cfg.cfg_write_address = '0;
      cfg.cfg_write_data    = '0;
      cfg.cfg_read_valid    = 1'b0;
      cfg.cfg_read_address  = '0;
      model_reset();
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("ready_after_reset", {30'd0, cfg.cfg_write_ready, cfg.cfg_read_ready}, 32'd3);
      read_results();
      cfg_rd(8'h10);
      cfg_rd(8'h08);                        // unmapped

      // Scenario 1: all-ones weights, inputs 2..5
      load(2, 3, 4, 5, 1'b0);
      cfg_wr(8'h60, 32'd123);               // RO, dropped
      cfg_wr(8'h00, 32'd1);
      wait_idle(1000, n);
      chk("s1_latency", 32'(n), 32'd29);
      chk("s1_beats", 32'(beats_acc), 32'd16);
      finish_run(1'b1);
      chk("s1_model_pin", m_out[2], 32'd14);
      cfg_rd(8'h60);
      read_results();
      cfg_rd(8'h2C);

      // Scenario 2: identity weights, ReLU and IRQ enabled
      cfg_wr(8'h04, 32'hE);
      load(7, -3, 0, 9, 1'b1);
      cfg_wr(8'h00, 32'd7);
      wait_idle(1000, n);
      chk("s2_latency", 32'(n), 32'd29);
      finish_run(1'b1);
      chk("s2_model_pin", {m_out[0][7:0], m_out[1][7:0], m_out[2][7:0], m_out[3][7:0]}, 32'h07000009);
      chk("s2_irq_high", {31'd0, done_irq}, {31'd0, m_done & m_irq});
      read_results();
      cfg_wr(8'h04, 32'h2);
      chk("s2_irq_cleared", {31'd0, done_irq}, {31'd0, m_done & m_irq});

      // Scenario 3: ready toggling
      cfg_wr(8'h00, 32'd0);
      load(2, 3, 4, 5, 1'b0);
      ready_mode = 1;
      cfg_wr(8'h00, 32'd1);
      wait_idle(1000, n);
      chk("s3_beats", 32'(beats_acc), 32'd16);
      finish_run(1'b1);
      read_results();
      ready_mode = 0;

      // Scenario 4: MAC never answers
      cfg_wr(8'h04, 32'hE);
      res_en = 1'b0;
      cfg_wr(8'h00, 32'd1);
      wait_idle(2000, n);
      chk("s4_timeout_cycles", 32'(n), 32'd259);
      chk("s4_beats", 32'(beats_acc), 32'd4);
      finish_run(1'b0);
      res_en = 1'b1;
      read_results();

      // Scenario 5: writes while busy
      cfg_wr(8'h04, 32'hE);
      cfg_wr(8'h00, 32'd1);
      repeat (3) @(negedge clock);
      cfg_wr(8'h10, 32'd99);
      cfg_wr(8'h00, 32'd1);
      wait_idle(1000, n);
      finish_run(1'b1);
      read_results();
      cfg_rd(8'h10);
      cfg_wr(8'h04, 32'h8);
      cfg_rd(8'h04);

      // Scenario 6: reset during row 2, then a clean rerun
      cfg_wr(8'h00, 32'd1);
      repeat (15) @(negedge clock);
      reset_n = 1'b0;
      exp_beats.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(negedge clock);
      read_results();
      cfg_rd(8'h10);
      load(2, 3, 4, 5, 1'b0);
      cfg_wr(8'h00, 32'd1);
      wait_idle(1000, n);
      chk("s6_latency", 32'(n), 32'd29);
      finish_run(1'b1);
      read_results();

      // Randomized runs
      ready_mode = 2;
      for (int r = 0; r < 6; r++) begin
         cfg_wr(8'h04, 32'hE);
         for (int j = 0; j < 4; j++) cfg_wr(8'(8'h10 + 4 * j), 32'(int'($urandom_range(0, 100)) - 50));
         for (int k = 0; k < 16; k++) cfg_wr(8'(8'h20 + 4 * k), 32'(int'($urandom_range(0, 40)) - 20));
         mac_lat = int'($urandom_range(1, 4));
         cfg_wr(8'h00, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
         wait_idle(2000, n);
         finish_run(1'b1);
         chk("rnd_irq", {31'd0, done_irq}, {31'd0, m_done & m_irq});
         read_results();
         cfg_rd(8'(8'h20 + 4 * $urandom_range(0, 15)));
      end

      repeat (3) @(negedge clock);
      chk("reads_outstanding", 32'(exp_rd.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
